// File: rtl/clk_div_prog.sv
// Purpose: programmable integer clock divider with 50% duty for even and odd divisors.
// Latency: a loaded divisor takes effect at the next period boundary (at most D_old+1 cycles).
// Backpressure: none; div_load is always accepted, and a later load overwrites an unapplied one.
//
// Ports:
//   clk_in      source clock (posedge logic, plus one negedge retime flop)
//   reset       asynchronous active-low reset
//   div_in      divisor value captured by div_load
//   div_load    single-cycle strobe that captures div_in as the pending divisor
//   div_active  divisor currently in effect
//   div_pending high while a captured divisor waits for the period boundary
//   clk_out     divided clock
//   rise_tick   one clk_in cycle pulse at the start of each clk_out period
//   period_cnt  wrapping count of completed clk_out periods
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int PCNT_W      = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              div_load,
  output logic [DIV_W-1:0]  div_active,
  output logic              div_pending,
  output logic              clk_out,
  output logic              rise_tick,
  output logic [PCNT_W-1:0] period_cnt
);

  localparam logic [DIV_W-1:0]  DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0]  DIV_ONE = DIV_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  pend_q, pend_d;
  logic              pending_q, pending_d;
  logic              p_q, p_d;
  logic              n_q;
  logic              tick_q, tick_d;
  logic              started_q, started_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  logic              low_div;
  logic              last_cnt;
  logic              at_end;
  logic              apply;
  logic              wrap;
  logic [DIV_W-1:0]  new_div;
  logic [DIV_W-1:0]  eff_div;
  logic [DIV_W-1:0]  half_up;
  logic [DIV_W-1:0]  cnt_nxt;

  always_comb begin
    // D of 0 or 1 has no phase counter, so any pending divisor may apply on the next edge.
    low_div  = (div_q[DIV_W-1:1] == '0);
    last_cnt = (cnt_q == div_q - DIV_ONE);
    at_end   = started_q & (low_div | last_cnt);
    // A load arriving on the period-end edge is applied directly; at D<2 a load is
    // only captured and applies one edge later.
    apply    = at_end & (pending_q | (div_load & ~low_div));
    new_div  = div_load ? div_in : pend_q;
    // A period completes on every edge at D=1, and on counter wrap for D>=2.
    // The very first edge after reset opens a period rather than closing one.
    wrap     = started_q & ((div_q == DIV_ONE) | (~low_div & last_cnt));
    eff_div  = apply ? new_div : div_q;
    // ceil(D/2) without widening: no overflow at the maximum divisor.
    half_up  = (eff_div >> 1) + {{(DIV_W-1){1'b0}}, eff_div[0]};
    cnt_nxt  = (!started_q || apply || last_cnt) ? '0 : cnt_q + DIV_ONE;

    cnt_d     = cnt_q;
    p_d       = p_q;
    tick_d    = 1'b0;
    div_d     = div_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    pcnt_d    = pcnt_q;
    started_d = 1'b1;

    if (apply) begin
      div_d     = new_div;
      pending_d = 1'b0;
    end else if (div_load) begin
      pend_d    = div_in;
      pending_d = 1'b1;
    end

    if (wrap) begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end

    if (eff_div == '0) begin
      cnt_d  = '0;
      p_d    = 1'b0;
      tick_d = 1'b0;
    end else if (eff_div == DIV_ONE) begin
      cnt_d  = '0;
      p_d    = 1'b0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_nxt;
      p_d    = (cnt_nxt < half_up);
      tick_d = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      div_q     <= DEF_DIV;
      pend_q    <= '0;
      pending_q <= 1'b0;
      p_q       <= 1'b0;
      tick_q    <= 1'b0;
      started_q <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      p_q       <= p_d;
      tick_q    <= tick_d;
      started_q <= started_d;
      pcnt_q    <= pcnt_d;
    end
  end

  // Half-cycle delayed copy of the high phase; ANDing it in trims the odd-D high
  // phase by half a cycle at the start, giving an x.5 high / x.5 low waveform.
  always_ff @(negedge clk_in or negedge reset) begin
    if (!reset) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  always_comb begin
    clk_out = 1'b0;
    if (div_q == '0) begin
      clk_out = 1'b0;
    end else if (div_q == DIV_ONE) begin
      // Bypass, held low until the first edge after reset.
      clk_out = clk_in & started_q;
    end else if (div_q[0]) begin
      clk_out = p_q & n_q;
    end else begin
      clk_out = p_q;
    end
  end

  assign div_active  = div_q;
  assign div_pending = pending_q;
  assign rise_tick   = tick_q;
  assign period_cnt  = pcnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int DIV_W  = 8;
  localparam int PCNT_W = 8;

  logic              clk_in;
  logic              reset;
  logic [DIV_W-1:0]  div_in;
  logic              div_load;
  logic [DIV_W-1:0]  div_active;
  logic              div_pending;
  logic              clk_out;
  logic              rise_tick;
  logic [PCNT_W-1:0] period_cnt;

  clk_div_prog #(
    .DIV_W(DIV_W),
    .DEFAULT_DIV(2),
    .PCNT_W(PCNT_W)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .div_in     (div_in),
    .div_load   (div_load),
    .div_active (div_active),
    .div_pending(div_pending),
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .period_cnt (period_cnt)
  );

  // One expected clk_in cycle: clk_out just after the posedge and just after the
  // negedge, rise_tick, and whether period_cnt advances on that edge.
  typedef struct {
    logic pos_clk;
    logic neg_clk;
    logic tick;
    logic inc;
  } exp_t;

  exp_t              exp_q[$];
  int                errors;
  int                checks;
  logic [PCNT_W-1:0] exp_pcnt;

  logic              s_pos_clk;
  logic              s_neg_clk;
  logic              s_tick;
  logic [PCNT_W-1:0] s_pcnt;
  logic [DIV_W-1:0]  s_active;
  logic              s_pending;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected waveform for n cycles of divisor d starting at phase start_i.
  // first_inc < 0 derives the period-count step from the tick; otherwise forces it.
  task automatic push_cycles(input int d, input int start_i, input int n, input int first_inc);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int   i;
      int   c;
      i = (d == 0) ? 0 : (start_i + k) % d;
      c = d / 2 + d % 2;
      if (d == 0) begin
        e.pos_clk = 1'b0; e.neg_clk = 1'b0; e.tick = 1'b0;
      end else if (d == 1) begin
        e.pos_clk = 1'b1; e.neg_clk = 1'b0; e.tick = 1'b1;
      end else begin
        e.tick    = (i == 0);
        e.neg_clk = (i < c);
        e.pos_clk = (d % 2 == 1) ? (i >= 1 && i < c) : (i < c);
      end
      e.inc = e.tick;
      if (k == 0 && first_inc >= 0) e.inc = (first_inc != 0);
      exp_q.push_back(e);
    end
  endtask

  // Advance one clk_in cycle and capture DUT outputs after each edge.
  task automatic cycle();
    @(posedge clk_in);
    #1;
    div_load  = 1'b0;
    s_pos_clk = clk_out;
    s_tick    = rise_tick;
    s_pcnt    = period_cnt;
    s_active  = div_active;
    s_pending = div_pending;
    @(negedge clk_in);
    #1;
    s_neg_clk = clk_out;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    div_load = 1'b0;
    div_in   = '0;
    #12;
    checks += 5;
    if (clk_out !== 1'b0) begin errors++; $display("FAIL reset clk_out got %b want 0", clk_out); end
    if (rise_tick !== 1'b0) begin errors++; $display("FAIL reset rise_tick got %b want 0", rise_tick); end
    if (div_active !== 8'd2) begin errors++; $display("FAIL reset div_active got %0d want 2", div_active); end
    if (div_pending !== 1'b0) begin errors++; $display("FAIL reset div_pending got %b want 0", div_pending); end
    if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset period_cnt got %0d want 0", period_cnt); end
    exp_pcnt = '0;
    exp_q.delete();
    @(negedge clk_in);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_default_div();
    exp_t e;
    push_cycles(2, 0, 20, 0);
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL default_div scoreboard empty k=%0d", k); continue; end
      e = exp_q.pop_front();
      if (e.inc) exp_pcnt = exp_pcnt + 1'b1;
      checks += 4;
      if (s_pos_clk !== e.pos_clk) begin errors++; $display("FAIL default_div clk_out@pos k=%0d got %b want %b", k, s_pos_clk, e.pos_clk); end
      if (s_neg_clk !== e.neg_clk) begin errors++; $display("FAIL default_div clk_out@neg k=%0d got %b want %b", k, s_neg_clk, e.neg_clk); end
      if (s_tick !== e.tick) begin errors++; $display("FAIL default_div rise_tick k=%0d got %b want %b", k, s_tick, e.tick); end
      if (s_pcnt !== exp_pcnt) begin errors++; $display("FAIL default_div period_cnt k=%0d got %0d want %0d", k, s_pcnt, exp_pcnt); end
    end
    checks++;
    if (period_cnt !== 8'd9) begin errors++; $display("FAIL default_div final period_cnt got %0d want 9", period_cnt); end
  endtask

  // D=4 loaded on the period-end edge, then D=5 loaded mid-period.
  task automatic test_even_odd();
    exp_t e;
    div_in = 8'd4; div_load = 1'b1;
    push_cycles(4, 0, 10, -1);
    push_cycles(4, 2, 2, -1);
    push_cycles(5, 0, 15, -1);
    for (int k = 0; k < 27; k++) begin
      if (k == 10) begin div_in = 8'd5; div_load = 1'b1; end
      cycle();
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL even_odd scoreboard empty k=%0d", k); continue; end
      e = exp_q.pop_front();
      if (e.inc) exp_pcnt = exp_pcnt + 1'b1;
      checks += 4;
      if (s_pos_clk !== e.pos_clk) begin errors++; $display("FAIL even_odd clk_out@pos k=%0d got %b want %b", k, s_pos_clk, e.pos_clk); end
      if (s_neg_clk !== e.neg_clk) begin errors++; $display("FAIL even_odd clk_out@neg k=%0d got %b want %b", k, s_neg_clk, e.neg_clk); end
      if (s_tick !== e.tick) begin errors++; $display("FAIL even_odd rise_tick k=%0d got %b want %b", k, s_tick, e.tick); end
      if (s_pcnt !== exp_pcnt) begin errors++; $display("FAIL even_odd period_cnt k=%0d got %0d want %0d", k, s_pcnt, exp_pcnt); end
      if (k == 0 || k == 10 || k == 12) begin
        checks += 2;
        if (s_active !== ((k == 12) ? 8'd5 : 8'd4)) begin errors++; $display("FAIL even_odd div_active k=%0d got %0d", k, s_active); end
        if (s_pending !== (k == 10)) begin errors++; $display("FAIL even_odd div_pending k=%0d got %b want %b", k, s_pending, (k == 10)); end
      end
    end
  endtask

  // D=6, then 7 and 3 loaded back-to-back from cnt=1: 3 wins at the boundary.
  task automatic test_midperiod_change();
    exp_t e;
    div_in = 8'd6; div_load = 1'b1;
    push_cycles(6, 0, 2, -1);
    push_cycles(6, 2, 4, -1);
    push_cycles(3, 0, 6, -1);
    for (int k = 0; k < 12; k++) begin
      if (k == 2) begin div_in = 8'd7; div_load = 1'b1; end
      if (k == 3) begin div_in = 8'd3; div_load = 1'b1; end
      cycle();
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL midperiod scoreboard empty k=%0d", k); continue; end
      e = exp_q.pop_front();
      if (e.inc) exp_pcnt = exp_pcnt + 1'b1;
      checks += 4;
      if (s_pos_clk !== e.pos_clk) begin errors++; $display("FAIL midperiod clk_out@pos k=%0d got %b want %b", k, s_pos_clk, e.pos_clk); end
      if (s_neg_clk !== e.neg_clk) begin errors++; $display("FAIL midperiod clk_out@neg k=%0d got %b want %b", k, s_neg_clk, e.neg_clk); end
      if (s_tick !== e.tick) begin errors++; $display("FAIL midperiod rise_tick k=%0d got %b want %b", k, s_tick, e.tick); end
      if (s_pcnt !== exp_pcnt) begin errors++; $display("FAIL midperiod period_cnt k=%0d got %0d want %0d", k, s_pcnt, exp_pcnt); end
      checks += 2;
      if (s_pending !== (k >= 2 && k <= 5)) begin errors++; $display("FAIL midperiod div_pending k=%0d got %b want %b", k, s_pending, (k >= 2 && k <= 5)); end
      if (s_active !== ((k >= 6) ? 8'd3 : 8'd6)) begin errors++; $display("FAIL midperiod div_active k=%0d got %0d", k, s_active); end
    end
  endtask

  // D=1 bypass, D=0 stop, then D=2 resumes.
  task automatic test_bypass_stop();
    exp_t e;
    div_in = 8'd1; div_load = 1'b1;
    push_cycles(1, 0, 5, -1);
    push_cycles(1, 0, 1, -1);
    push_cycles(0, 0, 1, 1);
    push_cycles(0, 0, 6, -1);
    push_cycles(0, 0, 1, -1);
    push_cycles(2, 0, 6, 0);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) begin div_in = 8'd0; div_load = 1'b1; end
      if (k == 13) begin div_in = 8'd2; div_load = 1'b1; end
      cycle();
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL bypass_stop scoreboard empty k=%0d", k); continue; end
      e = exp_q.pop_front();
      if (e.inc) exp_pcnt = exp_pcnt + 1'b1;
      checks += 4;
      if (s_pos_clk !== e.pos_clk) begin errors++; $display("FAIL bypass_stop clk_out@pos k=%0d got %b want %b", k, s_pos_clk, e.pos_clk); end
      if (s_neg_clk !== e.neg_clk) begin errors++; $display("FAIL bypass_stop clk_out@neg k=%0d got %b want %b", k, s_neg_clk, e.neg_clk); end
      if (s_tick !== e.tick) begin errors++; $display("FAIL bypass_stop rise_tick k=%0d got %b want %b", k, s_tick, e.tick); end
      if (s_pcnt !== exp_pcnt) begin errors++; $display("FAIL bypass_stop period_cnt k=%0d got %0d want %0d", k, s_pcnt, exp_pcnt); end
      if (k == 5 || k == 6 || k == 13 || k == 14) begin
        checks += 2;
        if (s_pending !== (k == 5 || k == 13)) begin errors++; $display("FAIL bypass_stop div_pending k=%0d got %b", k, s_pending); end
        if (s_active !== ((k == 5) ? 8'd1 : (k == 14) ? 8'd2 : 8'd0)) begin errors++; $display("FAIL bypass_stop div_active k=%0d got %0d", k, s_active); end
      end
    end
  endtask

  // D=255 for two periods, then D=1 until period_cnt wraps through 255 -> 0.
  task automatic test_max_div();
    exp_t e;
    int   n;
    n = 258 - int'(exp_pcnt);
    div_in = 8'd255; div_load = 1'b1;
    push_cycles(255, 0, 510, -1);
    push_cycles(1, 0, n, -1);
    for (int k = 0; k < 510 + n; k++) begin
      if (k == 510) begin div_in = 8'd1; div_load = 1'b1; end
      cycle();
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL max_div scoreboard empty k=%0d", k); continue; end
      e = exp_q.pop_front();
      if (e.inc) exp_pcnt = exp_pcnt + 1'b1;
      checks += 4;
      if (s_pos_clk !== e.pos_clk) begin errors++; $display("FAIL max_div clk_out@pos k=%0d got %b want %b", k, s_pos_clk, e.pos_clk); end
      if (s_neg_clk !== e.neg_clk) begin errors++; $display("FAIL max_div clk_out@neg k=%0d got %b want %b", k, s_neg_clk, e.neg_clk); end
      if (s_tick !== e.tick) begin errors++; $display("FAIL max_div rise_tick k=%0d got %b want %b", k, s_tick, e.tick); end
      if (s_pcnt !== exp_pcnt) begin errors++; $display("FAIL max_div period_cnt k=%0d got %0d want %0d", k, s_pcnt, exp_pcnt); end
    end
  endtask

  // Reset asserted in the high phase of D=8 with a load pending.
  task automatic test_reset_midperiod();
    exp_t e;
    div_in = 8'd8; div_load = 1'b1;
    push_cycles(1, 0, 1, -1);
    push_cycles(8, 0, 2, -1);
    push_cycles(2, 0, 6, 0);
    for (int k = 0; k < 9; k++) begin
      if (k == 2) begin div_in = 8'd3; div_load = 1'b1; end
      if (k == 3) begin
        checks += 2;
        if (clk_out !== 1'b1) begin errors++; $display("FAIL reset_mid pre clk_out got %b want 1", clk_out); end
        if (div_pending !== 1'b1) begin errors++; $display("FAIL reset_mid pre div_pending got %b want 1", div_pending); end
        reset = 1'b0;
        #1;
        checks += 5;
        if (clk_out !== 1'b0) begin errors++; $display("FAIL reset_mid clk_out got %b want 0", clk_out); end
        if (div_active !== 8'd2) begin errors++; $display("FAIL reset_mid div_active got %0d want 2", div_active); end
        if (div_pending !== 1'b0) begin errors++; $display("FAIL reset_mid div_pending got %b want 0", div_pending); end
        if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset_mid period_cnt got %0d want 0", period_cnt); end
        if (rise_tick !== 1'b0) begin errors++; $display("FAIL reset_mid rise_tick got %b want 0", rise_tick); end
        #1;
        reset    = 1'b1;
        exp_pcnt = '0;
      end
      cycle();
      if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL reset_mid scoreboard empty k=%0d", k); continue; end
      e = exp_q.pop_front();
      if (e.inc) exp_pcnt = exp_pcnt + 1'b1;
      checks += 4;
      if (s_pos_clk !== e.pos_clk) begin errors++; $display("FAIL reset_mid clk_out@pos k=%0d got %b want %b", k, s_pos_clk, e.pos_clk); end
      if (s_neg_clk !== e.neg_clk) begin errors++; $display("FAIL reset_mid clk_out@neg k=%0d got %b want %b", k, s_neg_clk, e.neg_clk); end
      if (s_tick !== e.tick) begin errors++; $display("FAIL reset_mid rise_tick k=%0d got %b want %b", k, s_tick, e.tick); end
      if (s_pcnt !== exp_pcnt) begin errors++; $display("FAIL reset_mid period_cnt k=%0d got %0d want %0d", k, s_pcnt, exp_pcnt); end
    end
    checks++;
    if (div_active !== 8'd2) begin errors++; $display("FAIL reset_mid discarded load div_active got %0d want 2", div_active); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_default_div();
    test_even_odd();
    test_midperiod_change();
    test_bypass_stop();
    test_max_div();
    test_reset_midperiod();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
